mux_rr_arbiter: RTL

MUX_RR_ARBITER -- requirements
Module: mux_rr_arbiter

---
 rtl/mux_rr_arbiter.sv | 92 +++++++++
 1 files changed

// File: rtl/mux_rr_arbiter.sv
// Four-requester round-robin arbiter muxing 10-bit words onto one registered,
// back-pressured channel. Define MUX_ARB_HOLD_EN to allow bursts of up to 4 words per winner.
module mux_rr_arbiter #(
  parameter int DATA_W = 10
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data_input,
  output logic [3:0]            ack,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     out_data,
  output logic [1:0]            out_src,
  input  logic                  out_ready
);

  // First asserted request in the order last+1, last+2, last+3, last.
  function automatic logic [1:0] rr_pick(input logic [3:0] r, input logic [1:0] last);
    logic [1:0] idx;
    logic [1:0] pick;
    pick = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + 2'(k);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  function automatic logic [DATA_W-1:0] word_sel(input logic [4*DATA_W-1:0] d,
                                                 input logic [1:0] sel);
    return d[sel*DATA_W +: DATA_W];
  endfunction

  function automatic logic [3:0] onehot(input logic [1:0] sel);
    return 4'b0001 << sel;
  endfunction

  logic [1:0]        ptr;
  logic              load_p0;
  logic              take_p0;
  logic [1:0]        win_p0;
  logic [DATA_W-1:0] word_p0;

`ifdef MUX_ARB_HOLD_EN
  logic [1:0] burst_cnt;
  logic       granted;
  logic       hold_p0;

  // The pointer only means "current burst owner" once something was granted.
  assign hold_p0 = granted & req[ptr] & (burst_cnt != 2'd3);
  assign win_p0  = hold_p0 ? ptr : rr_pick(req, ptr);

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_cnt <= 2'd0;
      granted   <= 1'b0;
    end else if (take_p0) begin
      granted <= 1'b1;
      if (granted && (win_p0 == ptr))
        burst_cnt <= (burst_cnt == 2'd3) ? 2'd3 : burst_cnt + 2'd1;
      else
        burst_cnt <= 2'd0;
    end
  end
`else
  assign win_p0 = rr_pick(req, ptr);
`endif

  // Stage 0: grant decision and word select, all combinational.
  assign load_p0 = ~out_valid | out_ready;
  assign take_p0 = load_p0 & (|req) & ~reset;
  assign word_p0 = word_sel(data_input, win_p0);
  assign ack     = take_p0 ? onehot(win_p0) : 4'b0000;

  // Stage 1: registered output channel.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= 2'd0;
      ptr       <= 2'd3;
    end else if (take_p0) begin
      out_valid <= 1'b1;
      out_data  <= word_p0;
      out_src   <= win_p0;
      ptr       <= win_p0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
